// File: rtl/uart_frame_parser.sv
// Deframer for SOF/LEN/payload/CHK packets arriving as byte strobes; releases only
// checksum-clean payloads downstream and keeps saturating frame/drop statistics.
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 50_000,
  parameter int         CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic [2:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] frame_ok_count,
  output logic [CNT_WIDTH-1:0] frame_err_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       MAX_LEN_9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_LEN = 3'd1,
    GET_PAY = 3'd2,
    GET_CHK = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [8:0]       len;
  logic [7:0]       xor_acc;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       store [MAX_LEN];

  logic             timed;
  logic             timeout_hit;
  logic [8:0]       len_in;
  logic             len_bad;
  logic             pay_last;
  logic             chk_ok;
  logic             xfer;
  logic             err_evt;
  logic             ok_evt;
  logic             drop_evt;
  logic [IDX_W-1:0] rd_next;
  logic             rd_next_last;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign timed        = (state == GET_LEN) || (state == GET_PAY) || (state == GET_CHK);
  assign timeout_hit  = timed && !rx_valid && (tmo_cnt == TMO_LAST);
  assign len_in       = {1'b0, rx_data};
  assign len_bad      = (len_in == 9'd0) || (len_in > MAX_LEN_9);
  assign pay_last     = (9'(wr_idx) == len - 9'd1);
  assign xfer         = out_valid && out_ready;
  assign rd_next      = rd_idx + IDX_W'(1);
  assign rd_next_last = (9'(rd_next) == len - 9'd1);

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    err_evt    = 1'b0;
    ok_evt     = 1'b0;
    drop_evt   = 1'b0;
    chk_ok     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid && rx_data == SOF_BYTE) next_state = GET_LEN;
      end
      GET_LEN: begin
        if (timeout_hit) begin
          err_evt    = 1'b1;
          next_state = IDLE;
        end else if (rx_valid) begin
          if (len_bad) begin
            err_evt    = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = GET_PAY;
          end
        end
      end
      GET_PAY: begin
        if (timeout_hit) begin
          err_evt    = 1'b1;
          next_state = IDLE;
        end else if (rx_valid && pay_last) begin
          next_state = GET_CHK;
        end
      end
      GET_CHK: begin
        if (timeout_hit) begin
          err_evt    = 1'b1;
          next_state = IDLE;
        end else if (rx_valid) begin
          if (rx_data == xor_acc) begin
            chk_ok     = 1'b1;
            next_state = DRAIN;
          end else begin
            err_evt    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        drop_evt = rx_valid;
        if (xfer && out_last) begin
          ok_evt     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture datapath and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len             <= '0;
      xor_acc         <= '0;
      wr_idx          <= '0;
      rd_idx          <= '0;
      tmo_cnt         <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_last        <= 1'b0;
      frame_ok_count  <= '0;
      frame_err_count <= '0;
      drop_count      <= '0;
    end else begin
      if (!timed || rx_valid || timeout_hit) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + TMO_W'(1);

      unique case (state)
        GET_LEN: begin
          if (rx_valid) begin
            len     <= len_in;
            xor_acc <= rx_data;
            wr_idx  <= '0;
          end
        end
        GET_PAY: begin
          if (rx_valid) begin
            xor_acc <= xor_acc ^ rx_data;
            wr_idx  <= wr_idx + IDX_W'(1);
          end
        end
        GET_CHK: begin
          if (chk_ok) begin
            out_valid <= 1'b1;
            out_data  <= store[0];
            out_last  <= (len == 9'd1);
            rd_idx    <= '0;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_idx   <= rd_next;
              out_data <= store[rd_next[ADDR_W-1:0]];
              out_last <= rd_next_last;
            end
          end
        end
        default: ;
      endcase

      if (ok_evt)   frame_ok_count  <= sat_inc(frame_ok_count);
      if (err_evt)  frame_err_count <= sat_inc(frame_err_count);
      if (drop_evt) drop_count      <= sat_inc(drop_count);
    end
  end

  // NOTE: the payload store is deliberately not reset; it is always written
  // before it is read, and leaving it out of reset keeps it plain registers/RAM.
  always_ff @(posedge clk) begin
    if (state == GET_PAY && rx_valid) store[wr_idx[ADDR_W-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus pushes expected payload beats,
// a monitor pops and compares them as the DUT transfers them.
module tb_uart_frame_parser;

  localparam int CW  = 4;
  localparam int TMO = 100;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [2:0]    state_dbg;
  logic [CW-1:0] frame_ok_count;
  logic [CW-1:0] frame_err_count;
  logic [CW-1:0] drop_count;

  beat_t      exp_q[$];
  logic [7:0] tx[$];
  int         n_checks = 0;
  int         n_err    = 0;

  uart_frame_parser #(
    .SOF_BYTE      (8'hA5),
    .MAX_LEN       (64),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .state_dbg      (state_dbg),
    .frame_ok_count (frame_ok_count),
    .frame_err_count(frame_err_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask

  // Sends tx back-to-back, one byte per clock; returns 1 time unit after the last edge.
  task automatic send_tx();
    foreach (tx[i]) begin
      rx_data  = tx[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, (k < 500), 1);
  endtask

  task automatic check_counts(input string name, input int ok, input int err, input int drop);
    check({name, "_ok"},   frame_ok_count,  ok);
    check({name, "_err"},  frame_err_count, err);
    check({name, "_drop"}, drop_count,      drop);
  endtask

  initial begin : monitor
    logic       stall;
    logic [7:0] hd;
    logic       hl;
    beat_t      e;
    stall = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data",  out_data,  hd);
        check("hold_last",  out_last,  hl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out: got %0h, no byte expected", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
      end
      stall = out_valid && !out_ready;
      hd    = out_data;
      hl    = out_last;
    end
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_busy",  busy,      0);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last,  0);
    check("rst_data",  out_data,  0);
    check_counts("rst", 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: good frame, streamed on consecutive cycles
    push_exp(8'h11, 1'b0);
    push_exp(8'h22, 1'b0);
    push_exp(8'h33, 1'b1);
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_tx();
    for (int i = 0; i < 3; i++) begin
      check("t1_stream_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    check("t1_end_valid", out_valid, 0);
    wait_done("t1_done");
    check_counts("t1", 1, 0, 0);

    // 2: bad checksum rejected, next good frame accepted
    tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_tx();
    check("t2_state", state_dbg, 0);
    check_counts("t2_bad", 1, 1, 0);
    push_exp(8'h5A, 1'b0);
    push_exp(8'hC3, 1'b1);
    tx = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    send_tx();
    wait_done("t2_done");
    check_counts("t2_good", 2, 1, 0);

    // 3: noise ignored, zero and oversize lengths rejected, max length accepted
    tx = '{8'h00, 8'hFF};
    send_tx();
    check("t3_noise_state", state_dbg, 0);
    check_counts("t3_noise", 2, 1, 0);
    tx = '{8'hA5, 8'h00};
    send_tx();
    check("t3_len0_state", state_dbg, 0);
    check_counts("t3_len0", 2, 2, 0);
    tx = '{8'hA5, 8'h41};
    send_tx();
    check("t3_len65_state", state_dbg, 0);
    check_counts("t3_len65", 2, 3, 0);
    tx = '{8'hA5, 8'h40};
    for (int i = 0; i < 64; i++) begin
      tx.push_back(8'(i));
      push_exp(8'(i), (i == 63));
    end
    tx.push_back(8'h40);
    send_tx();
    wait_done("t3_max_done");
    check_counts("t3_max", 3, 3, 0);

    // 4: inter-byte timeout, exact boundary, then recovery with a 1-byte frame
    tx = '{8'hA5, 8'h02, 8'h11};
    send_tx();
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("t4_pre_state", state_dbg, 2);
    @(posedge clk);
    #1;
    check("t4_post_state", state_dbg, 0);
    check_counts("t4_tmo", 3, 4, 0);
    push_exp(8'h7E, 1'b1);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_tx();
    wait_done("t4_done");
    check_counts("t4_rec", 4, 4, 0);

    // 5: backpressure mid-drain with two bytes dropped
    push_exp(8'h10, 1'b0);
    push_exp(8'h20, 1'b0);
    push_exp(8'h30, 1'b0);
    push_exp(8'h40, 1'b1);
    tx = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
    send_tx();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx_valid = (i == 2) || (i == 5);
      rx_data  = (i == 2) ? 8'hA5 : 8'h55;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("t5_held_valid", out_valid, 1);
    check("t5_held_data",  out_data,  8'h20);
    check("t5_state",      state_dbg, 4);
    out_ready = 1'b1;
    wait_done("t5_done");
    check_counts("t5", 5, 4, 2);

    // 6: asynchronous reset mid-payload, then drop counter saturation
    tx = '{8'hA5, 8'h03, 8'h11};
    send_tx();
    check("t6_pre_state", state_dbg, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_state", state_dbg, 0);
    check("t6_rst_busy",  busy,      0);
    check("t6_rst_valid", out_valid, 0);
    check_counts("t6_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_exp(8'h7E, 1'b1);
    tx = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_tx();
    tx = {};
    for (int i = 0; i < 20; i++) tx.push_back((i % 2 == 0) ? 8'hA5 : 8'h01);
    send_tx();
    check("t6_sat_state", state_dbg, 4);
    check("t6_sat_drop",  drop_count, 4'hF);
    out_ready = 1'b1;
    wait_done("t6_done");
    check("t6_final_state", state_dbg, 0);
    check_counts("t6_final", 1, 0, 15);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
